// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    int n;
    n = width / NIBBLE;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ripcar.sv
// Combinational 4-bit ripple-carry adder stage shared by all nibbles.
module ripcar_adder_4bit
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              ci,
  output logic [NIBBLE-1:0] s,
  output logic              co
);

  logic [NIBBLE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder sequencing one 4-bit ripple stage over N nibbles, LSB first.
// Optional subtract mode (sub port) is compiled in with SUBTRACT_EN.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 2 * NIBBLE) begin : g_width_chk
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t            state, state_nxt;
  op_t               op_q;
  logic [CW-1:0]     cnt;
  logic              c_reg;
  logic              accept;
  logic              last;
  logic [WIDTH-1:0]  b_lat;
  logic              c_lat;
  logic [NIBBLE-1:0] nib_a, nib_b, nib_s;
  logic              nib_co;

  // Subtract is a + ~b + 1, folded into the operand/carry latch.
  always_comb begin
    b_lat = b;
    c_lat = carry_in;
`ifdef SUBTRACT_EN
    if (sub) begin
      b_lat = ~b;
      c_lat = 1'b1;
    end
`endif
  end

  assign nib_a = op_q.a[cnt*NIBBLE +: NIBBLE];
  assign nib_b = op_q.b[cnt*NIBBLE +: NIBBLE];
  assign last  = (cnt == LAST);

  ripcar_adder_4bit u_stage (
    .a  (nib_a),
    .b  (nib_b),
    .ci (c_reg),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A new request in the done cycle starts immediately.
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      cnt       <= '0;
      c_reg     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q.a <= a;
        op_q.b <= b_lat;
        c_reg  <= c_lat;
        cnt    <= '0;
      end else if (state == RUN) begin
        sum[cnt*NIBBLE +: NIBBLE] <= nib_s;
        c_reg <= nib_co;
        cnt   <= cnt + 1'b1;
        if (last) carry_out <= nib_co;
      end
    end
  end

endmodule
